// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide issue sequencer.
package md_pkg;

    localparam int MD_MULT_LAT = 5;
    localparam int MD_DIV_LAT  = 10;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

endpackage

// File: rtl/md_sequencer.sv
// Issue/completion control for the external multiply/divide datapath.
// Owns architectural HI/LO and drives busy/start/stall for hazards.
module md_sequencer
    import md_pkg::*;
#(
    parameter int MULT_LAT = MD_MULT_LAT,
    parameter int DIV_LAT  = MD_DIV_LAT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        req_i,
    input  logic        d_is_md_i,
    output logic [3:0]  dp_op_o,
    output logic [31:0] dp_a_o,
    output logic [31:0] dp_b_o,
    input  logic [31:0] dp_hi_i,
    input  logic [31:0] dp_lo_i,
    output logic        start_o,
    output logic        busy_o,
    output logic        stall_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [31:0] rd_data_o
);

    localparam int MAXL = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW   = $clog2(MAXL + 1);

    localparam logic [CW-1:0] MUL_END = CW'(MULT_LAT);
    localparam logic [CW-1:0] DIV_END = CW'(DIV_LAT);

    md_state_e     state;
    logic [CW-1:0] cnt;

    logic is_mul;
    logic is_div;
    logic can_go;
    logic dp_div0;

    assign is_mul  = (op_i == MD_MULT) || (op_i == MD_MULTU);
    assign is_div  = (op_i == MD_DIV)  || (op_i == MD_DIVU);
    assign can_go  = (state == ST_IDLE) && valid_i && !req_i;
    assign start_o = can_go && (is_mul || is_div);
    assign busy_o  = (state != ST_IDLE);
    assign stall_o = d_is_md_i && (busy_o || start_o);

    // A zero divisor runs the full latency but leaves HI/LO untouched
    assign dp_div0 = ((dp_op_o == MD_DIV) || (dp_op_o == MD_DIVU))
                     && (dp_b_o == 32'd0);

    always_comb begin
        rd_data_o = 32'd0;
        if (op_i == MD_MFHI)
            rd_data_o = hi_o;
        else if (op_i == MD_MFLO)
            rd_data_o = lo_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            hi_o    <= 32'd0;
            lo_o    <= 32'd0;
            dp_op_o <= 4'd0;
            dp_a_o  <= 32'd0;
            dp_b_o  <= 32'd0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start_o) begin
                        dp_op_o <= op_i;
                        dp_a_o  <= a_i;
                        dp_b_o  <= b_i;
                        cnt     <= CW'(1);
                        state   <= is_mul ? ST_MUL : ST_DIV;
                    end else if (can_go && (op_i == MD_MTHI)) begin
                        hi_o <= a_i;
                    end else if (can_go && (op_i == MD_MTLO)) begin
                        lo_o <= a_i;
                    end
                end
                ST_MUL: begin
                    if (cnt == MUL_END) begin
                        hi_o  <= dp_hi_i;
                        lo_o  <= dp_lo_i;
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DIV: begin
                    if (cnt == DIV_END) begin
                        if (!dp_div0) begin
                            hi_o <= dp_hi_i;
                            lo_o <= dp_lo_i;
                        end
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Cycle-accurate scoreboard bench for md_sequencer.
// Stimulus queues per-cycle expectations; a negedge monitor checks them.
module tb_md_sequencer;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        req, dmd;
    logic [3:0]  dp_op;
    logic [31:0] dp_a, dp_b, dp_hi, dp_lo;
    logic        start, busy, stall;
    logic [31:0] hi, lo, rd;

    md_sequencer dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid), .op_i(op),
        .a_i(a), .b_i(b), .req_i(req), .d_is_md_i(dmd),
        .dp_op_o(dp_op), .dp_a_o(dp_a), .dp_b_o(dp_b),
        .dp_hi_i(dp_hi), .dp_lo_i(dp_lo),
        .start_o(start), .busy_o(busy), .stall_o(stall),
        .hi_o(hi), .lo_o(lo), .rd_data_o(rd)
    );

    always #5 clk = ~clk;

    // Combinational datapath stand-in; a zero divisor yields junk
    always_comb begin
        dp_hi = 32'd0;
        dp_lo = 32'd0;
        case (dp_op)
            MD_MULT:
                {dp_hi, dp_lo} = $signed({{32{dp_a[31]}}, dp_a})
                               * $signed({{32{dp_b[31]}}, dp_b});
            MD_MULTU:
                {dp_hi, dp_lo} = {32'd0, dp_a} * {32'd0, dp_b};
            MD_DIV:
                if (dp_b != 32'd0) begin
                    dp_lo = $signed(dp_a) / $signed(dp_b);
                    dp_hi = $signed(dp_a) % $signed(dp_b);
                end else begin
                    dp_hi = 32'hDEADBEEF;
                    dp_lo = 32'hDEADBEEF;
                end
            MD_DIVU:
                if (dp_b != 32'd0) begin
                    dp_lo = dp_a / dp_b;
                    dp_hi = dp_a % dp_b;
                end else begin
                    dp_hi = 32'hDEADBEEF;
                    dp_lo = 32'hDEADBEEF;
                end
            default: ;
        endcase
    end

    typedef struct {
        int          id;
        logic        s, bz, st;
        logic [31:0] hi, lo, rd;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   step_id = 0;

    task automatic chk(input string nm, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h want %h", nm, id, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("start", e.id, {31'd0, start}, {31'd0, e.s});
            chk("busy",  e.id, {31'd0, busy},  {31'd0, e.bz});
            chk("stall", e.id, {31'd0, stall}, {31'd0, e.st});
            chk("hi",    e.id, hi, e.hi);
            chk("lo",    e.id, lo, e.lo);
            chk("rd",    e.id, rd, e.rd);
        end
    end

    task automatic step(input logic r, v, input logic [3:0] o,
                        input logic [31:0] ia, ib,
                        input logic rq, dm,
                        input logic es, eb, est,
                        input logic [31:0] ehi, elo, erd);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r;
        valid = v;
        op    = o;
        a     = ia;
        b     = ib;
        req   = rq;
        dmd   = dm;
        step_id++;
        e.id = step_id;
        e.s  = es;
        e.bz = eb;
        e.st = est;
        e.hi = ehi;
        e.lo = elo;
        e.rd = erd;
        q.push_back(e);
    endtask

    initial begin
        valid = 0; op = MD_NONE; a = 0; b = 0; req = 0; dmd = 0;

        step(0,0,MD_NONE,0,0,0,0, 0,0,0, 0,0,0);

        // MULT -3 * 7
        step(1,1,MD_MULT,32'hFFFFFFFD,7,0,0, 1,0,0, 0,0,0);
        repeat (5) step(1,0,MD_NONE,0,0,0,0, 0,1,0, 0,0,0);
        step(1,1,MD_MFLO,0,0,0,0, 0,0,0,
             32'hFFFFFFFF,32'hFFFFFFEB,32'hFFFFFFEB);

        // DIVU 100 / 7
        step(1,1,MD_DIVU,100,7,0,0, 1,0,0, 32'hFFFFFFFF,32'hFFFFFFEB,0);
        repeat (9) step(1,0,MD_NONE,0,0,0,0, 0,1,0,
                        32'hFFFFFFFF,32'hFFFFFFEB,0);
        step(1,1,MD_MFLO,0,0,0,0, 0,1,0,
             32'hFFFFFFFF,32'hFFFFFFEB,32'hFFFFFFEB);
        step(1,1,MD_MFLO,0,0,0,0, 0,0,0, 2,14,14);

        // MTLO 0, MTHI 0x1234, DIV by zero
        step(1,1,MD_MTLO,0,0,0,0, 0,0,0, 2,14,0);
        step(1,1,MD_MTHI,32'h1234,0,0,0, 0,0,0, 2,0,0);
        step(1,1,MD_MFHI,0,0,0,0, 0,0,0, 32'h1234,0,32'h1234);
        step(1,1,MD_DIV,5,0,0,0, 1,0,0, 32'h1234,0,0);
        repeat (10) step(1,0,MD_NONE,0,0,0,0, 0,1,0, 32'h1234,0,0);
        step(1,1,MD_MFHI,0,0,0,0, 0,0,0, 32'h1234,0,32'h1234);

        // MULTU cancelled by req, then retried
        step(1,1,MD_MULTU,3,4,1,0, 0,0,0, 32'h1234,0,0);
        step(1,1,MD_MULTU,3,4,0,0, 1,0,0, 32'h1234,0,0);
        repeat (5) step(1,0,MD_NONE,0,0,0,0, 0,1,0, 32'h1234,0,0);
        step(1,0,MD_NONE,0,0,0,0, 0,0,0, 0,12,0);

        // MULT 2 * -1 with D-stage MD op held and req mid-flight
        step(1,1,MD_MULT,2,32'hFFFFFFFF,0,1, 1,0,1, 0,12,0);
        repeat (2) step(1,0,MD_NONE,0,0,0,1, 0,1,1, 0,12,0);
        step(1,1,MD_NONE,0,0,1,1, 0,1,1, 0,12,0);
        repeat (2) step(1,0,MD_NONE,0,0,0,1, 0,1,1, 0,12,0);
        step(1,0,MD_NONE,0,0,0,1, 0,0,0, 32'hFFFFFFFF,32'hFFFFFFFE,0);

        // DIV aborted by reset in busy cycle 4
        step(1,1,MD_DIV,20,3,0,0, 1,0,0, 32'hFFFFFFFF,32'hFFFFFFFE,0);
        repeat (3) step(1,0,MD_NONE,0,0,0,0, 0,1,0,
                        32'hFFFFFFFF,32'hFFFFFFFE,0);
        step(0,0,MD_NONE,0,0,0,0, 0,0,0, 0,0,0);
        repeat (12) step(1,0,MD_NONE,0,0,0,0, 0,0,0, 0,0,0);

        #20;
        chk("queue_drained", 0, q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Issue and completion controller for the CPU's multiply/divide unit, between the E-stage and a combinational multiply/divide datapath. It accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from the E-stage and latches the operands for the datapath. It counts the fixed latency, commits HI/LO, and drives busy/start for the hazard unit. Operations are cancelled when an exception/interrupt request coincides with issue.

## Interface
- MULT_LAT, 5, cycles busy for mult/multu (≥1)
- DIV_LAT, 10, cycles busy for div/divu (≥1)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid_i  in  1  E-stage holds a real instruction (not bubble)
- op_i  in  4  MD op code (package enum)
- a_i  in  32  rs operand
- b_i  in  32  rt operand
- req_i  in  1  exception/interrupt request; the E-stage instruction is cancelled this cycle
- d_is_md_i  in  1  D-stage instruction is any MD op (including mfhi/mflo/mthi/mtlo)
- dp_op_o  out  4  latched op to datapath
- dp_a_o, dp_b_o  out  32  latched operands to datapath
- dp_hi_i, dp_lo_i  in  32  datapath result, stable while dp_* are held
- start_o  out  1  combinational; issue accepted this cycle
- busy_o  out  1  registered; operation in flight
- stall_o  out  1  combinational; hold D-stage
- hi_o, lo_o  out  32  architectural HI/LO
- rd_data_o  out  32  mfhi/mflo read data

## Operation
- Op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8. All other codes are treated as NONE.
- FSM states: IDLE, MUL, DIV.
  - IDLE→MUL on issue of MULT/MULTU.
  - IDLE→DIV on issue of DIV/DIVU.
  - MUL/DIV→IDLE when cnt==LAT.
- Issue condition: state IDLE && valid_i && !req_i && op is MULT..DIVU.
  - start_o = issue condition.
  - At the issue edge: latch op/a/b into dp_*, set cnt←1.
- In MUL/DIV: cnt increments each edge. At the edge where cnt==LAT: HI←dp_hi_i, LO←dp_lo_i, cnt←0, state←IDLE.
- Divide by zero (latched b==0 with DIV/DIVU): full DIV_LAT latency, HI/LO unchanged at completion.
- MTHI/MTLO: when state IDLE && valid_i && !req_i, HI (resp. LO)←a_i at the edge. Ignored while busy.
- MD ops arriving while busy are ignored. The hazard unit, via stall_o, guarantees this never happens.
- rd_data_o = hi_o for MFHI, lo_o for MFLO, else 0. It reflects the committed value and does not forward in-flight results.
- stall_o = d_is_md_i && (busy_o || start_o).
- req_i during MUL/DIV does not abort. The issued operation completes and commits.
- busy_o = (state != IDLE).

## Timing
- Reset (async, rst_n=0): state IDLE, cnt 0, HI=LO=0, dp_op_o=0, dp_a_o=dp_b_o=0, busy_o=0. Combinational outputs follow from this.
- Reset mid-operation aborts it: no commit, HI/LO=0.
- Issue in cycle t: start_o high in t, busy_o high cycles t+1…t+LAT, HI/LO new value visible from t+LAT+1.
- Back-to-back issue earliest at t+LAT+1. No zero-bubble issue in the completion cycle.
- req_i and issue in the same cycle: start_o=0, no state change.
- mthi in cycle t: hi_o updated from t+1. An mfhi in cycle t reads the old value.

## Structure
- Shared package md_pkg: op enum md_op_e, state enum md_state_e, latency defaults.
- Counter width: $clog2(max(MULT_LAT, DIV_LAT)+1).
- Single module. No sub-module needed; the datapath stays external.

## Test plan
- Reset, then MULT a=0xFFFFFFFD b=7 → start_o=1 one cycle, busy_o 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIVU a=100 b=7 → busy_o 10 cycles, then HI=2, LO=14. mflo in the cycle after busy falls returns 14.
- MTHI 0x1234, then DIV a=5 b=0 → after 10 cycles HI=0x1234 and LO unchanged (0).
- MULTU with req_i=1 in the issue cycle → start_o=0, busy_o stays 0, HI/LO unchanged. Retried next cycle without req → normal completion.
- MULT issued, d_is_md_i=1 held → stall_o high in the issue cycle and all 5 busy cycles, low the cycle after. req_i pulsed mid-op → commit still occurs.
- DIV issued, rst_n=0 at busy cycle 4 → busy_o=0, HI=LO=0 immediately. No commit after reset release.
